// File: rtl/glb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : glb_ctrl
//  Description : Global-buffer transaction controller. Clears the GLB,
//                fills it with a burst of upstream words starting at a base
//                address (modulo depth), then drains the same rows to the
//                downstream port in arrival order, one word per 3 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module glb_ctrl #(
  parameter int num_bits  = 16,
  parameter int addr_bits = 6
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  input  logic                 w_start,
  input  logic [addr_bits:0]   w_len,
  input  logic [addr_bits-1:0] w_base,
  input  logic                 w_in_valid,
  input  logic [num_bits-1:0]  w_in_data,
  output logic                 r_in_ready,
  output logic                 r_out_valid,
  output logic [num_bits-1:0]  r_out_data,
  input  logic                 w_out_ready,
  output logic                 r_glb_ready,
  output logic                 r_glb_rw,
  output logic [addr_bits-1:0] r_glb_address,
  output logic [num_bits-1:0]  r_glb_data_in,
  input  logic [num_bits-1:0]  w_glb_data_out,
  output logic                 r_busy,
  output logic                 r_done,
  output logic                 r_err
);

  // Largest legal transaction length equals the GLB depth (2^addr_bits).
  localparam logic [addr_bits:0]   c_max_len = {1'b1, {addr_bits{1'b0}}};
  localparam logic [addr_bits:0]   c_one_len = {{addr_bits{1'b0}}, 1'b1};
  localparam logic [addr_bits-1:0] c_one_idx = {{(addr_bits-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_FILL     = 3'd2,
    S_RD_ADDR  = 3'd3,
    S_RD_DATA  = 3'd4,
    S_OUT_WAIT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [addr_bits-1:0] r_index;
  logic [addr_bits-1:0] w_index_nxt;
  logic [addr_bits-1:0] r_base;
  logic [addr_bits:0]   r_len;
  logic                 w_len_ok;
  logic                 w_start_ok;
  logic                 w_last;
  logic [addr_bits-1:0] w_addr;

  assign w_len_ok   = (w_len != '0) && (w_len <= c_max_len);
  assign w_start_ok = (r_state == S_IDLE) && w_start && w_len_ok;
  // Index runs 0..len-1; len-1 always fits in addr_bits bits.
  assign w_last     = ({1'b0, r_index} == (r_len - c_one_len));
  // Truncating add gives the modulo-depth wrap for free.
  assign w_addr     = r_base + r_index;
  assign r_busy     = (r_state != S_IDLE);

  // State, index and latched transaction parameters.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_base  <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      if (w_start_ok) begin
        r_base <= w_base;
        r_len  <= w_len;
      end
    end
  end

  // Next-state logic and state-decoded GLB / handshake outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_index_nxt   = r_index;
    r_in_ready    = 1'b0;
    r_out_valid   = 1'b0;
    r_glb_ready   = 1'b0;
    r_glb_rw      = 1'b0;
    r_glb_address = '0;
    r_glb_data_in = '0;
    r_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_CLEAR;
          w_index_nxt = '0;
        end
      end
      S_CLEAR: begin
        // GLB enable held low for one edge wipes the buffer.
        w_state_nxt = S_FILL;
      end
      S_FILL: begin
        r_glb_ready   = 1'b1;
        r_in_ready    = 1'b1;
        r_glb_rw      = w_in_valid;
        r_glb_address = w_addr;
        r_glb_data_in = w_in_data;
        if (w_in_valid) begin
          if (w_last) begin
            w_index_nxt = '0;
            w_state_nxt = S_RD_ADDR;
          end else begin
            w_index_nxt = r_index + c_one_idx;
          end
        end
      end
      S_RD_ADDR: begin
        r_glb_ready   = 1'b1;
        r_glb_address = w_addr;
        w_state_nxt   = S_RD_DATA;
      end
      S_RD_DATA: begin
        r_glb_ready   = 1'b1;
        r_glb_address = w_addr;
        w_state_nxt   = S_OUT_WAIT;
      end
      S_OUT_WAIT: begin
        r_glb_ready   = 1'b1;
        r_glb_address = w_addr;
        r_out_valid   = 1'b1;
        if (w_out_ready) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_index_nxt = r_index + c_one_idx;
            w_state_nxt = S_RD_ADDR;
          end
        end
      end
      S_DONE: begin
        r_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture the fetched GLB word; it stays stable through OUT_WAIT.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out_data <= '0;
    end else if (r_state == S_RD_DATA) begin
      r_out_data <= w_glb_data_out;
    end
  end

  // One-cycle error pulse for a start with an out-of-range length.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && w_start && !w_len_ok;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_glb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_glb_ctrl
//  Description : Directed self-checking bench for glb_ctrl with a
//                behavioural synchronous-read GLB model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_glb_ctrl;

  localparam int NB = 16;
  localparam int AB = 6;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          start     = 1'b0;
  logic [AB:0]   len       = '0;
  logic [AB-1:0] base      = '0;
  logic          in_valid  = 1'b0;
  logic [NB-1:0] in_data   = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, glb_ready, glb_rw, busy, done, err;
  logic [NB-1:0] out_data, glb_data_in;
  logic [NB-1:0] glb_dout = '0;
  logic [AB-1:0] glb_addr;

  logic [NB-1:0] mem   [64];
  logic [NB-1:0] words [64];

  int passed   = 0;
  int total    = 0;
  int done_cnt = 0;

  glb_ctrl #(.num_bits(NB), .addr_bits(AB)) dut (
    .w_clk         (clk),
    .w_rst_n       (rst_n),
    .w_start       (start),
    .w_len         (len),
    .w_base        (base),
    .w_in_valid    (in_valid),
    .w_in_data     (in_data),
    .r_in_ready    (in_ready),
    .r_out_valid   (out_valid),
    .r_out_data    (out_data),
    .w_out_ready   (out_ready),
    .r_glb_ready   (glb_ready),
    .r_glb_rw      (glb_rw),
    .r_glb_address (glb_addr),
    .r_glb_data_in (glb_data_in),
    .w_glb_data_out(glb_dout),
    .r_busy        (busy),
    .r_done        (done),
    .r_err         (err)
  );

  always #5 clk = ~clk;

  // GLB model: enable low clears, rw=1 stores, rw=0 registers a fetch.
  always @(posedge clk) begin
    if (!glb_ready) begin
      for (int k = 0; k < 64; k++) mem[k] <= '0;
      glb_dout <= '0;
    end else if (glb_rw) begin
      mem[glb_addr] <= glb_data_in;
    end else begin
      glb_dout <= mem[glb_addr];
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string t);
    check_b({t, "_in_ready"},  in_ready,  1'b0);
    check_b({t, "_out_valid"}, out_valid, 1'b0);
    check_w({t, "_out_data"},  32'(out_data), 32'h0);
    check_b({t, "_glb_ready"}, glb_ready, 1'b0);
    check_b({t, "_glb_rw"},    glb_rw,    1'b0);
    check_w({t, "_glb_addr"},  32'(glb_addr), 32'h0);
    check_w({t, "_glb_din"},   32'(glb_data_in), 32'h0);
    check_b({t, "_busy"},      busy,      1'b0);
    check_b({t, "_done"},      done,      1'b0);
    check_b({t, "_err"},       err,       1'b0);
  endtask

  // Full transaction starting at posedge+1 in IDLE; checks every cycle.
  task automatic run_txn(input logic [AB-1:0] b, input int n, input int stall_at,
                         input bit fill_gap, input bit start_in_fill);
    int d0;
    logic [AB-1:0] a;
    d0 = done_cnt;
    start = 1'b1; len = (AB+1)'(n); base = b;
    tick;
    start = 1'b0;
    #1;
    check_b("clear_busy", busy, 1'b1);
    check_b("clear_glb_ready", glb_ready, 1'b0);
    check_b("clear_in_ready", in_ready, 1'b0);
    tick;
    if (fill_gap) begin
      in_valid = 1'b0;
      #1;
      check_b("gap_in_ready", in_ready, 1'b1);
      check_b("gap_rw", glb_rw, 1'b0);
      tick;
    end
    for (int i = 0; i < n; i++) begin
      a = b + AB'(i);
      in_valid = 1'b1;
      in_data  = words[i];
      if (start_in_fill && i == 1) begin
        start = 1'b1; len = 7'd3; base = 6'd20;
      end
      #1;
      check_b("fill_in_ready", in_ready, 1'b1);
      check_b("fill_glb_ready", glb_ready, 1'b1);
      check_b("fill_rw", glb_rw, 1'b1);
      check_w("fill_addr", 32'(glb_addr), 32'(a));
      check_w("fill_din", 32'(glb_data_in), 32'(words[i]));
      tick;
      start = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = b + AB'(i);
      #1;
      check_b("rd_addr_glb_ready", glb_ready, 1'b1);
      check_b("rd_addr_rw", glb_rw, 1'b0);
      check_b("rd_addr_in_ready", in_ready, 1'b0);
      check_b("rd_addr_out_valid", out_valid, 1'b0);
      check_w("rd_addr_addr", 32'(glb_addr), 32'(a));
      tick;
      #1;
      check_b("rd_data_out_valid", out_valid, 1'b0);
      check_w("rd_data_addr", 32'(glb_addr), 32'(a));
      tick;
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          check_b("stall_out_valid", out_valid, 1'b1);
          check_w("stall_out_data", 32'(out_data), 32'(words[i]));
          check_w("stall_addr", 32'(glb_addr), 32'(a));
          tick;
        end
        out_ready = 1'b1;
      end
      #1;
      check_b("out_valid", out_valid, 1'b1);
      check_w("out_data", 32'(out_data), 32'(words[i]));
      check_b("out_in_ready", in_ready, 1'b0);
      tick;
    end
    out_ready = 1'b0;
    #1;
    check_b("done_pulse", done, 1'b1);
    check_b("done_glb_ready", glb_ready, 1'b0);
    check_b("done_busy", busy, 1'b1);
    tick;
    #1;
    check_b("post_done", done, 1'b0);
    check_b("post_busy", busy, 1'b0);
    check_w("done_count", 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    int d0;
    // Asynchronous reset asserted between edges.
    #2 rst_n = 1'b0;
    #1 check_zero("rst_init");
    tick; tick;
    rst_n = 1'b1;

    // Basic 4-word transaction, base 0.
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    run_txn(6'd0, 4, -1, 1'b0, 1'b0);

    // Address wrap: 62, 63, 0, 1, with an idle FILL cycle first.
    words[0] = 16'hA0A1; words[1] = 16'hB2B3; words[2] = 16'hC4C5; words[3] = 16'hD6D7;
    run_txn(6'd62, 4, -1, 1'b1, 1'b0);

    // Downstream stall of 5 cycles on the second word.
    words[0] = 16'h0F0F; words[1] = 16'hF0F0; words[2] = 16'h5A5A;
    run_txn(6'd7, 3, 1, 1'b0, 1'b0);

    // Rejected starts: len 0 and len 65.
    start = 1'b1; len = 7'd0; base = 6'd3;
    tick; start = 1'b0; #1;
    check_b("err_len0", err, 1'b1);
    check_b("err_len0_busy", busy, 1'b0);
    tick; #1;
    check_b("err_len0_clear", err, 1'b0);
    check_b("err_len0_busy2", busy, 1'b0);
    start = 1'b1; len = 7'd65;
    tick; start = 1'b0; #1;
    check_b("err_len65", err, 1'b1);
    check_b("err_len65_busy", busy, 1'b0);
    tick; #1;
    check_b("err_len65_clear", err, 1'b0);
    check_b("err_len65_busy2", busy, 1'b0);
    tick;

    // Start asserted mid-FILL must not disturb the transaction.
    for (int i = 0; i < 5; i++) words[i] = 16'h1000 + 16'(i * 16'h0111);
    run_txn(6'd5, 5, -1, 1'b0, 1'b1);

    // Length boundaries: 1 and 64 (full depth, wrapping from 33).
    words[0] = 16'hBEEF;
    run_txn(6'd40, 1, -1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) words[i] = 16'hC000 ^ 16'(i * 37);
    run_txn(6'd33, 64, -1, 1'b0, 1'b0);

    // Reset after two FILL accepts abandons the transaction.
    d0 = done_cnt;
    start = 1'b1; len = 7'd4; base = 6'd10;
    tick; start = 1'b0;
    tick;
    in_valid = 1'b1; in_data = 16'h7777;
    tick;
    in_data = 16'h8888;
    tick;
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    tick; tick;
    check_w("rst_no_done", 32'(done_cnt), 32'(d0));
    rst_n = 1'b1;

    // First start after reset release is honoured immediately.
    words[0] = 16'h0123; words[1] = 16'h4567; words[2] = 16'h89AB; words[3] = 16'hCDEF;
    run_txn(6'd10, 4, -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glb_ctrl.md
GLB_CTRL -- requirements
Module: glb_ctrl

Interface
REQ-001 Parameter num_bits, default 16, GLB word width.
REQ-002 Parameter addr_bits, default 6, GLB address width; depth = 2^addr_bits = 64.
REQ-003 w_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 w_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 w_start  in  1  begin a transaction when high in IDLE.
REQ-006 w_len  in  addr_bits+1  transaction word count; valid range 1..64.
REQ-007 w_base  in  addr_bits  first GLB address of the transaction.
REQ-008 w_in_valid  in  1  upstream word valid.
REQ-009 w_in_data  in  num_bits  upstream word.
REQ-010 r_in_ready  out  1  controller accepts an upstream word.
REQ-011 r_out_valid  out  1  downstream word valid.
REQ-012 r_out_data  out  num_bits  downstream word, registered.
REQ-013 w_out_ready  in  1  downstream accepts a word.
REQ-014 r_glb_ready  out  1  GLB enable; low clears the GLB on each clock edge.
REQ-015 r_glb_rw  out  1  GLB mode: 1 = store w_data_in, 0 = fetch to data output.
REQ-016 r_glb_address  out  addr_bits  GLB row address.
REQ-017 r_glb_data_in  out  num_bits  word to store in the GLB.
REQ-018 w_glb_data_out  in  num_bits  GLB data output; meaningful only while r_glb_ready=1 and r_glb_rw=0.
REQ-019 r_busy  out  1  high in every state except IDLE.
REQ-020 r_done  out  1  one-cycle pulse at transaction end.
REQ-021 r_err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-022 States SHALL be IDLE, CLEAR, FILL, RD_ADDR, RD_DATA, OUT_WAIT, DONE.
REQ-023 IDLE: r_glb_ready=0, r_in_ready=0, r_out_valid=0.
REQ-024 IDLE + w_start + w_len in 1..64: latch w_base and w_len, index=0, go to CLEAR.
REQ-025 IDLE + w_start + (w_len=0 or w_len>64): r_err pulses next cycle; state stays IDLE.
REQ-026 w_start outside IDLE SHALL be ignored.
REQ-027 CLEAR: one cycle, r_glb_ready=0; go to FILL.
REQ-028 FILL: r_glb_ready=1, r_in_ready=1, r_glb_rw=w_in_valid (combinational), r_glb_address=(base+index) mod 64, r_glb_data_in=w_in_data.
REQ-029 FILL accept = w_in_valid & r_in_ready; each accept increments index; accept with index=len-1 resets index to 0 and moves to RD_ADDR.
REQ-030 RD_ADDR: r_glb_ready=1, r_glb_rw=0, address=(base+index) mod 64; next state RD_DATA.
REQ-031 RD_DATA: same GLB drive as RD_ADDR; at the edge, r_out_data <= w_glb_data_out, r_out_valid <= 1; next state OUT_WAIT.
REQ-032 OUT_WAIT: r_out_valid=1; r_out_data stable; GLB drive held.
REQ-033 OUT_WAIT on w_out_ready: r_out_valid clears. If index=len-1, go to DONE; otherwise index+1 and go to RD_ADDR.
REQ-034 Drain throughput SHALL be one word per 3 cycles with w_out_ready held high.
REQ-035 Output order SHALL equal input order.
REQ-036 Address arithmetic SHALL wrap modulo 64 (base=62, len=4 gives addresses 62, 63, 0, 1).
REQ-037 DONE: r_done=1 for one cycle, r_glb_ready=0; next state IDLE.
REQ-038 r_in_ready and r_glb_rw SHALL never both be 1 outside FILL.

Reset
REQ-039 w_rst_n low SHALL force immediately, without waiting for a clock edge:
- state IDLE, index 0
- r_in_ready=0, r_out_valid=0, r_out_data=0
- r_glb_ready=0, r_glb_rw=0, r_glb_address=0, r_glb_data_in=0
- r_busy=0, r_done=0, r_err=0
REQ-040 Reset mid-transaction SHALL abandon the transaction without a r_done pulse; GLB content is undefined afterwards.
REQ-041 After w_rst_n rises, the first w_start SHALL be honoured on the next rising edge.

Verification
REQ-042 Reset: assert w_rst_n=0 mid-cycle -> all outputs zero before the next edge.
REQ-043 base=0, len=4, inputs 0x1111/0x2222/0x3333/0x4444, w_out_ready=1:
- r_out_data sequence 0x1111, 0x2222, 0x3333, 0x4444
- r_done pulses exactly once
- 1 CLEAR cycle, then 4 FILL cycles, then 12 drain cycles.
REQ-044 base=62, len=4 -> r_glb_address sequence 62, 63, 0, 1 in both FILL and drain.
REQ-045 w_out_ready low for 5 cycles in OUT_WAIT -> r_out_valid=1 and r_out_data unchanged for 5 cycles; no word lost.
REQ-046 Error and ignored starts:
- w_len=0 -> r_err single pulse, r_busy stays 0
- w_len=65 -> same response
- w_start during FILL -> no effect on the transaction.
REQ-047 Reset asserted after 2 FILL accepts -> IDLE, r_done never pulses; a new transaction then completes correctly.
